// File: rtl/uart_dbg_cmd.sv
// UART debug command engine: decodes Read/Write/Exec commands from the RX byte
// stream, performs 32-bit OBI word accesses and answers on the TX byte stream.
module uart_dbg_cmd #(
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [3:0]           obi_be_o,
  output logic [31:0]          obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [31:0]          obi_rdata_i,
  input  logic                 obi_err_i,
  output logic                 exec_o,
  output logic [AddrWidth-1:0] exec_addr_o,
  input  logic                 eoc_i,
  output logic                 err_o
);

  localparam logic [7:0] OpRead  = 8'h11;
  localparam logic [7:0] OpWrite = 8'h12;
  localparam logic [7:0] OpExec  = 8'h13;
  localparam logic [7:0] ByteAck = 8'h06;
  localparam logic [7:0] ByteEot = 8'h04;
  localparam logic [7:0] ByteEoc = 8'h14;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_LEN, GET_WDATA, BUS_REQ,
    BUS_WAIT, SEND_RDATA, SEND_ACK, SEND_EOT, SEND_EOC
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             op_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [LenWidth-1:0]    len_q;
  logic [1:0]             byte_cnt_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   eoc_pending_q;
  logic                   is_opcode;
  logic [AddrWidth-1:0]   addr_shift;
  logic [LenWidth-1:0]    len_shift;
  logic [31:0]            wdata_shift;

  assign is_opcode = (rx_data_i == OpRead) || (rx_data_i == OpWrite) || (rx_data_i == OpExec);

  // Little-endian fields shift in from the top; the address is kept word aligned
  // at every step, which only discards bits that are shifted out anyway.
  assign addr_shift  = {rx_data_i, addr_q[AddrWidth-1:10], 2'b00};
  assign len_shift   = {rx_data_i, len_q[LenWidth-1:8]};
  assign wdata_shift = {rx_data_i, wdata_q[31:8]};

  assign obi_addr_o  = addr_q;
  assign obi_we_o    = obi_req_o && (op_q == OpWrite);
  assign obi_be_o    = 4'hF;
  assign obi_wdata_o = wdata_q;

  always_comb begin
    state_d    = state_q;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    obi_req_o  = 1'b0;
    case (state_q)
      IDLE: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          if (is_opcode) state_d = GET_ADDR;
        end else if (eoc_pending_q) begin
          state_d = SEND_EOC;
        end
      end
      GET_ADDR: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i && byte_cnt_q == 2'd3)
          state_d = (op_q == OpExec) ? SEND_ACK : GET_LEN;
      end
      GET_LEN: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i && byte_cnt_q == 2'd1) begin
          if (len_shift == '0)         state_d = SEND_ACK;
          else if (op_q == OpRead)     state_d = BUS_REQ;
          else                         state_d = GET_WDATA;
        end
      end
      GET_WDATA: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i && byte_cnt_q == 2'd3) state_d = BUS_REQ;
      end
      BUS_REQ: begin
        obi_req_o = 1'b1;
        if (obi_gnt_i) state_d = BUS_WAIT;
      end
      BUS_WAIT: begin
        if (obi_rvalid_i) begin
          if (op_q == OpRead)             state_d = SEND_RDATA;
          else if (len_q == LenWidth'(1)) state_d = SEND_ACK;
          else                            state_d = GET_WDATA;
        end
      end
      SEND_RDATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rdata_q[{byte_cnt_q, 3'b000} +: 8];
        if (tx_ready_i && byte_cnt_q == 2'd3)
          state_d = (len_q == '0) ? SEND_ACK : BUS_REQ;
      end
      SEND_ACK: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ByteAck;
        if (tx_ready_i) state_d = (op_q == OpRead) ? SEND_EOT : IDLE;
      end
      SEND_EOT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ByteEot;
        if (tx_ready_i) state_d = IDLE;
      end
      SEND_EOC: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ByteEoc;
        if (tx_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) rx_ready_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      byte_cnt_q    <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      eoc_pending_q <= 1'b0;
      exec_o        <= 1'b0;
      exec_addr_o   <= '0;
      err_o         <= 1'b0;
    end else begin
      state_q <= state_d;
      exec_o  <= 1'b0;
      // A new Eoc pulse wins over the clear caused by sending the previous one.
      eoc_pending_q <= eoc_i || (eoc_pending_q && !(state_q == SEND_EOC && tx_ready_i));
      case (state_q)
        IDLE: begin
          if (rx_valid_i && is_opcode) begin
            op_q       <= rx_data_i;
            byte_cnt_q <= 2'd0;
            err_o      <= 1'b0;
          end
        end
        GET_ADDR: begin
          if (rx_valid_i) begin
            addr_q     <= addr_shift;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3 && op_q == OpExec) begin
              exec_addr_o <= addr_shift;
              exec_o      <= 1'b1;
            end
          end
        end
        GET_LEN: begin
          if (rx_valid_i) begin
            len_q      <= len_shift;
            byte_cnt_q <= (byte_cnt_q == 2'd1) ? 2'd0 : byte_cnt_q + 2'd1;
          end
        end
        GET_WDATA: begin
          if (rx_valid_i) begin
            wdata_q    <= wdata_shift;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        BUS_WAIT: begin
          if (obi_rvalid_i) begin
            err_o  <= err_o | obi_err_i;
            addr_q <= addr_q + AddrWidth'(4);
            len_q  <= len_q - LenWidth'(1);
            if (op_q == OpRead) rdata_q <= obi_rdata_i;
          end
        end
        SEND_RDATA: begin
          if (tx_ready_i) byte_cnt_q <= byte_cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_cmd.sv
// Directed self-checking bench for uart_dbg_cmd with a small OBI memory model
// and monitors that collect TX bytes and exec pulses.
module tb_uart_dbg_cmd;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;
  logic        exec_o;
  logic [31:0] exec_addr_o;
  logic        eoc_i;
  logic        err_o;

  uart_dbg_cmd dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .exec_o(exec_o), .exec_addr_o(exec_addr_o), .eoc_i(eoc_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] mem [8];
  int          errIdx = -1;
  logic [7:0]  txq [$];
  logic [31:0] logAddr [$];
  logic [31:0] logWdata [$];
  logic        logWe [$];
  logic [3:0]  logBe [$];
  int          execCount = 0;
  logic [31:0] execAddrSeen = '0;
  logic [31:0] respData;
  logic        respErr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // OBI memory: grant one cycle after the request is seen, respond the cycle after.
  initial begin
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
    respData = '0; respErr = 1'b0;
    forever begin
      @(negedge clk_i);
      if (obi_gnt_i) begin
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = respData;
        obi_err_i    = respErr;
      end else begin
        obi_rvalid_i = 1'b0;
        obi_err_i    = 1'b0;
        obi_rdata_i  = '0;
        if (obi_req_o) begin
          obi_gnt_i = 1'b1;
          logAddr.push_back(obi_addr_o);
          logWdata.push_back(obi_wdata_o);
          logWe.push_back(obi_we_o);
          logBe.push_back(obi_be_o);
          respErr = (int'(obi_addr_o[4:2]) == errIdx);
          if (obi_we_o) begin
            mem[obi_addr_o[4:2]] = obi_wdata_o;
            respData = '0;
          end else begin
            respData = mem[obi_addr_o[4:2]];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
      if (exec_o) begin
        execCount++;
        execAddrSeen = exec_addr_o;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    int  cycles = 0;
    bit  done = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!done && cycles < 200) begin
      @(negedge clk_i);
      if (rx_ready_o) done = 1;
      @(posedge clk_i); #1;
      cycles++;
    end
    rx_valid_i = 1'b0;
    if (!done) checkOutput("rx_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic sendCmd(input logic [7:0] bytes [$]);
    foreach (bytes[i]) applyStimulus(bytes[i]);
  endtask

  task automatic checkTx(input string tag, input logic [7:0] exp [$]);
    int cycles = 0;
    while (txq.size() < exp.size() && cycles < 2000) begin
      @(posedge clk_i); #1;
      cycles++;
    end
    repeat (20) begin @(posedge clk_i); #1; end
    checkOutput({tag, "_count"}, 64'(txq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i),
                  (i < txq.size()) ? {56'd0, txq[i]} : 64'hFFFF, {56'd0, exp[i]});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] cmd [$];
    logic [7:0] held;
    bit         stable;
    int         obiBase;
    int         cycles;

    mem[0] = 32'h0BAD_0BAD; mem[1] = 32'hCAFE_F00D; mem[2] = 32'hA5A5_0001; mem[3] = '0;
    mem[4] = '0; mem[5] = '0; mem[6] = '0; mem[7] = '0;
    rst_i = 1'b1; rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b1; eoc_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_ctrl", {58'd0, rx_ready_o, tx_valid_o, obi_req_o, exec_o, err_o, obi_we_o}, 64'd0);
    checkOutput("reset_addrs", {exec_addr_o, obi_addr_o}, 64'd0);
    checkOutput("reset_wdata", {32'd0, obi_wdata_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    $display("[TB] write one word");
    cmd = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    sendCmd(cmd);
    checkTx("wr", '{8'h06});
    checkOutput("wr_obi_count", 64'(logAddr.size()), 64'd1);
    if (logAddr.size() >= 1) begin
      checkOutput("wr_addr", {32'd0, logAddr[0]}, 64'h1000_0000);
      checkOutput("wr_wdata", {32'd0, logWdata[0]}, 64'h1234_5678);
      checkOutput("wr_we_be", {59'd0, logWe[0], logBe[0]}, 64'h1F);
    end

    $display("[TB] read two words");
    txq.delete(); logAddr.delete(); logWe.delete(); logWdata.delete(); logBe.delete();
    cmd = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h10, 8'h02, 8'h00};
    sendCmd(cmd);
    checkTx("rd", '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h06, 8'h04});
    checkOutput("rd_obi_count", 64'(logAddr.size()), 64'd2);
    if (logAddr.size() >= 2) begin
      checkOutput("rd_addr0", {32'd0, logAddr[0]}, 64'h1000_0000);
      checkOutput("rd_addr1", {32'd0, logAddr[1]}, 64'h1000_0004);
      checkOutput("rd_we", {62'd0, logWe[0], logWe[1]}, 64'd0);
    end

    $display("[TB] exec");
    txq.delete();
    cmd = '{8'h13, 8'h82, 8'h00, 8'h00, 8'h10};
    sendCmd(cmd);
    checkTx("exec", '{8'h06});
    checkOutput("exec_pulses", 64'(execCount), 64'd1);
    checkOutput("exec_addr_pulse", {32'd0, execAddrSeen}, 64'h1000_0080);
    checkOutput("exec_addr_held", {32'd0, exec_addr_o}, 64'h1000_0080);

    $display("[TB] garbage byte then zero-length read");
    txq.delete();
    obiBase = logAddr.size();
    cmd = '{8'h55, 8'h11, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    sendCmd(cmd);
    checkTx("rd0", '{8'h06, 8'h04});
    checkOutput("rd0_no_obi", 64'(logAddr.size() - obiBase), 64'd0);

    $display("[TB] TX stall with bus error");
    txq.delete();
    errIdx = 2;
    tx_ready_i = 1'b0;
    cmd = '{8'h11, 8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00};
    sendCmd(cmd);
    cycles = 0;
    do begin
      @(negedge clk_i);
      cycles++;
    end while (!tx_valid_o && cycles < 200);
    checkOutput("stall_tx_valid", {63'd0, tx_valid_o}, 64'd1);
    held = tx_data_o;
    stable = 1;
    repeat (10) begin
      @(negedge clk_i);
      if (tx_data_o !== held || tx_valid_o !== 1'b1) stable = 0;
    end
    checkOutput("stall_first_byte", {56'd0, held}, 64'h01);
    checkOutput("stall_stable", {63'd0, stable}, 64'd1);
    checkOutput("stall_err_set", {63'd0, err_o}, 64'd1);
    @(posedge clk_i); #1;
    tx_ready_i = 1'b1;
    checkTx("err_rd", '{8'h01, 8'h00, 8'hA5, 8'hA5, 8'h06, 8'h04});
    checkOutput("err_sticky", {63'd0, err_o}, 64'd1);
    errIdx = -1;
    txq.delete();
    applyStimulus(8'h11);
    checkOutput("err_cleared", {63'd0, err_o}, 64'd0);
    cmd = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    sendCmd(cmd);
    checkTx("after_err", '{8'h06, 8'h04});

    $display("[TB] eoc during three-word read");
    txq.delete();
    cmd = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h10, 8'h03, 8'h00};
    sendCmd(cmd);
    cycles = 0;
    while (txq.size() < 1 && cycles < 500) begin
      @(posedge clk_i); #1;
      cycles++;
    end
    eoc_i = 1'b1;
    @(posedge clk_i); #1;
    eoc_i = 1'b0;
    checkTx("eoc", '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA,
                     8'h01, 8'h00, 8'hA5, 8'hA5, 8'h06, 8'h04, 8'h14});
    checkOutput("eoc_no_err", {63'd0, err_o}, 64'd0);

    $display("[TB] reset during write data");
    txq.delete();
    obiBase = logAddr.size();
    cmd = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'hAA, 8'hBB};
    sendCmd(cmd);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("midrst_ctrl", {58'd0, rx_ready_o, tx_valid_o, obi_req_o, exec_o, err_o, obi_we_o}, 64'd0);
    checkOutput("midrst_addrs", {exec_addr_o, obi_addr_o}, 64'd0);
    checkOutput("midrst_wdata", {32'd0, obi_wdata_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("postrst_rx_ready", {63'd0, rx_ready_o}, 64'd1);
    @(posedge clk_i); #1;
    cmd = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    sendCmd(cmd);
    checkTx("postrst", '{8'h06, 8'h04});
    checkOutput("postrst_no_obi", 64'(logAddr.size() - obiBase), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
